qmac_accum: RTL
===============

// Module: qmac_accum
// PURPOSE
//  Downstream accumulator for the sign-magnitude fixed-point multiplier: takes a stream of
//  (N,Q) products plus their overflow flags and sums one vector (e.g. neuron weighted sum).
//  Emits one saturated sign-magnitude (N,Q) sum per vector over a valid/ready handshake.
// PARAMETERS
//  N   16  total word width; bit N-1 = sign, bits N-2:0 = magnitude
//  Q   12  fractional bits; binary point unchanged by accumulation
//  G   4   guard bits in internal two's-complement accumulator (width N+G)
//  CW  8   width of beat counter o_beats
// PORTS
//  i_clk        in   1    clock, rising edge
//  i_rst        in   1    reset, asynchronous, active-high
//  i_product    in   N    sign-magnitude product from multiplier
//  i_prod_ovr   in   1    multiplier overflow flag for this product
//  i_valid      in   1    product beat valid
//  i_last       in   1    beat is last of vector
//  o_ready      out  1    block accepts a beat
//  o_sum        out  N    sign-magnitude saturated vector sum
//  o_ovr        out  1    sticky: any i_prod_ovr in vector, or output/accumulator saturation
//  o_beats      out  CW   beats accepted in vector (saturates at 2^CW-1)
//  o_valid      out  1    o_sum/o_ovr/o_beats valid
//  i_ready      in   1    downstream accepts result
//  i_bias       in   N    sign-magnitude start value (only with QMAC_BIAS_EN)
// BEHAVIOUR
//  - Reset: state=S_IDLE, acc=0, o_sum=0, o_ovr=0, o_beats=0, o_valid=0, o_ready=1.
//  - FSM: S_IDLE -accept-> S_ACC (or S_OUT if i_last); S_ACC -accept&i_last-> S_OUT;
//    S_OUT -(o_valid&i_ready)-> S_IDLE, acc/ovr/beats cleared. Accept = i_valid&o_ready.
//  - o_ready = 1 in S_IDLE/S_ACC, 0 in S_OUT; beats offered in S_OUT are not consumed.
//    One bubble between vectors: no input accepted in the output-handshake cycle.
//  - Conversion: mag=i_product[N-2:0]; term = sign ? -mag : +mag, sign-extended to N+G.
//    Negative zero (0x8000 at N=16) converts to 0.
//  - Accumulate: first beat acc=start+term (start=0, or bias), later beats acc+=term.
//    acc clamps at +/-(2^(N+G-1)-1); a clamp sets ovr.
//  - Latency: o_valid rises the cycle after the i_last beat is accepted; o_sum, o_ovr,
//    o_beats held stable while o_valid=1 and i_ready=0.
//  - Output: |acc| > 2^(N-1)-1 -> o_sum={sign,all-ones mag}, ovr=1; else {sign,|acc|}.
//    A zero sum is always emitted with sign 0.
//  - o_ovr = OR of i_prod_ovr over accepted beats, OR internal/output saturation.
//  - i_last on first beat = 1-beat vector. Async reset mid-vector drops partial sum.
// CONFIGURATION
//  QMAC_BIAS_EN defined: i_bias port exists; first beat loads acc=conv(i_bias)+term.
//  Undefined: no i_bias port; start value is 0.
// STRUCTURE
//  Package qfix_pkg: N/Q/G defaults, state enum (S_IDLE,S_ACC,S_OUT), SM_MAG_MAX const.
//  Sub-module qsm_to_tc: sign-magnitude -> (N+G) two's complement; used for product and bias.
// TESTING (N=16,Q=12; 1.0=0x1000)
//  1 beats 0x1000, 0x0800(last), i_ready=1 -> o_sum=0x1800, o_beats=2, o_ovr=0, 1 cycle.
//  2 beats 0x1000, 0x8800(last) -> 0x0800; beats 0x8800, 0x0800(last) -> 0x0000 (not 0x8000).
//  3 four beats 0x7000 -> o_sum=0x7FFF, o_ovr=1; two beats 0xF000 -> 0xFFFF, o_ovr=1.
//  4 beat 0x0100 with i_prod_ovr=1, then 0x0100(last) -> o_sum=0x0200, o_ovr=1.
//  5 i_ready=0 for 3 cycles after o_valid -> o_sum stable, o_ready=0; next vector correct.
//  6 i_rst pulse after 2 beats -> all outputs 0; new vector 0x0400(last) -> 0x0400.
//  7 QMAC_BIAS_EN, i_bias=0x9000, beat 0x0800(last) -> o_sum=0x8800.

Source files
------------

// File: rtl/qfix_pkg.sv
// Shared constants and FSM state type for the sign-magnitude fixed-point MAC datapath.
package qfix_pkg;
  localparam int QF_N  = 16;
  localparam int QF_Q  = 12;
  localparam int QF_G  = 4;
  localparam int QF_CW = 8;
  localparam logic [QF_N-2:0] SM_MAG_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;
endpackage

// File: rtl/qsm_to_tc.sv
// Sign-magnitude (N) to two's complement (N+G); negative zero maps to zero.
module qsm_to_tc #(
  parameter int N = 16,
  parameter int G = 4
) (
  input  logic [N-1:0]   sm,
  output logic [N+G-1:0] tc
);
  logic [N+G-1:0] mag;

  assign mag = {{(G+1){1'b0}}, sm[N-2:0]};
  assign tc  = sm[N-1] ? (~mag + 1'b1) : mag;
endmodule

// File: rtl/qmac_accum.sv
// Vector accumulator for sign-magnitude (N,Q) products with saturated sign-magnitude output.
// Optional start value via `define QMAC_BIAS_EN (adds the i_bias port).
// Handshakes: a beat transfers when i_valid & o_ready on a rising edge; a result
// transfers when o_valid & i_ready; o_ready is low for the whole result-holding state.
module qmac_accum
  import qfix_pkg::*;
#(
  parameter int N  = QF_N,
  parameter int G  = QF_G,
  parameter int CW = QF_CW
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [N-1:0]  i_product,
  input  logic          i_prod_ovr,
  input  logic          i_valid,
  input  logic          i_last,
  output logic          o_ready,
  output logic [N-1:0]  o_sum,
  output logic          o_ovr,
  output logic [CW-1:0] o_beats,
  output logic          o_valid,
  input  logic          i_ready,
`ifdef QMAC_BIAS_EN
  input  logic [N-1:0]  i_bias,
`endif
  output state_t        o_state
);
  localparam int AW = N + G;
  localparam logic signed [AW:0] ACC_MAX = {2'b00, {(AW-1){1'b1}}};
  localparam logic signed [AW:0] ACC_MIN = -ACC_MAX;
  localparam logic [N-2:0] MAG_ONES = '1;

  state_t               state, next_state;
  logic signed [AW-1:0] acc, acc_new, base, term, start;
  logic signed [AW:0]   sum_wide;
  logic [AW-1:0]        acc_abs;
  logic                 ovr, clamp, out_sat, accept, first;
  logic [CW-1:0]        beats;

  qsm_to_tc #(.N(N), .G(G)) u_conv_prod (.sm(i_product), .tc(term));

`ifdef QMAC_BIAS_EN
  qsm_to_tc #(.N(N), .G(G)) u_conv_bias (.sm(i_bias), .tc(start));
`else
  assign start = '0;
`endif

  always_comb begin
    next_state = state;
    o_ready    = 1'b0;
    o_valid    = 1'b0;
    case (state)
      S_IDLE, S_ACC: begin
        o_ready = 1'b1;
        if (i_valid) next_state = i_last ? S_OUT : S_ACC;
      end
      S_OUT: begin
        o_valid = 1'b1;
        if (i_ready) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  assign accept = i_valid & o_ready;
  assign first  = (state == S_IDLE);

  // One extra bit of headroom so the clamp sees the true sum before wrapping.
  always_comb begin
    base     = first ? start : acc;
    sum_wide = $signed({base[AW-1], base}) + $signed({term[AW-1], term});
    clamp    = 1'b0;
    acc_new  = sum_wide[AW-1:0];
    if (sum_wide > ACC_MAX) begin
      acc_new = ACC_MAX[AW-1:0];
      clamp   = 1'b1;
    end else if (sum_wide < ACC_MIN) begin
      acc_new = ACC_MIN[AW-1:0];
      clamp   = 1'b1;
    end
  end

  // acc never holds the most-negative code, so the negation below cannot overflow.
  always_comb begin
    acc_abs = acc[AW-1] ? (~acc + 1'b1) : acc;
    out_sat = |acc_abs[AW-1:N-1];
    o_sum   = out_sat ? {acc[AW-1], MAG_ONES} : {acc[AW-1], acc_abs[N-2:0]};
  end

  assign o_ovr   = ovr | out_sat;
  assign o_beats = beats;
  assign o_state = state;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= S_IDLE;
      acc   <= '0;
      ovr   <= 1'b0;
      beats <= '0;
    end else begin
      state <= next_state;
      if (accept) begin
        acc   <= acc_new;
        ovr   <= (first ? 1'b0 : ovr) | i_prod_ovr | clamp;
        if (first)          beats <= CW'(1);
        else if (beats != '1) beats <= beats + CW'(1);
      end else if (o_valid && i_ready) begin
        acc   <= '0;
        ovr   <= 1'b0;
        beats <= '0;
      end
    end
  end
endmodule
